// File: rtl/kuz_stream_ctrl_pkg.sv
// Shared widths, default latency and controller FSM state encoding for the
// Kuznechik stream controller slice.
package kuz_ctrl_pkg;

   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned KEY_W           = 256;
   localparam int unsigned DEFAULT_LATENCY = 128;

   typedef enum logic [1:0] {
      NOKEY = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      LOAD  = 2'd3
   } state_e;

endpackage

// File: rtl/kuz_stream_ctrl_if.sv
// Key, plaintext and ciphertext handshakes of the stream controller.
// master = traffic source/sink side, slave = controller side.
interface kuz_stream_ctrl_if;
   import kuz_ctrl_pkg::*;

   logic               key_valid;
   logic               key_ready;
   logic [KEY_W-1:0]   key_in;
   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_block;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_block;

   modport master (
      output key_valid, key_in, in_valid, in_block, out_ready,
      input  key_ready, in_ready, out_valid, out_block
   );

   modport slave (
      input  key_valid, key_in, in_valid, in_block, out_ready,
      output key_ready, in_ready, out_valid, out_block
   );

endinterface

// File: rtl/kuz_stream_ctrl_out_fifo.sv
// Synchronous output FIFO for ciphertext blocks; FIFO_DEPTH must be a power of two.
// Reads while empty present zero so the output bus is quiet after reset.
module kuz_out_fifo
   import kuz_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_i,
   input  logic [BLOCK_W-1:0]            din_i,
   input  logic                          pop_i,
   output logic [BLOCK_W-1:0]            dout_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          empty_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BLOCK_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_q, rd_q;
   logic [CW-1:0]      count_q, count_d;
   logic               do_pop, full;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      count_d = count_q;
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   // The upstream credit rule makes overflow unreachable; catch it if broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/kuz_stream_ctrl.sv
// Kuznechik stream controller: key-load FSM, credit-limited admission, fixed-latency
// valid tag pipe and output FIFO. Define KUZ_STREAM_CTRL_STATS_EN to add blk_count.
module kuz_stream_ctrl
   import kuz_ctrl_pkg::*;
#(
   parameter int unsigned LATENCY    = DEFAULT_LATENCY,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   kuz_stream_ctrl_if.slave   bus,
   output logic [BLOCK_W-1:0] enc_block,
   output logic [KEY_W-1:0]   enc_key,
   input  logic [BLOCK_W-1:0] enc_encoded,
   output logic               busy
`ifdef KUZ_STREAM_CTRL_STATS_EN
   ,
   output logic [31:0]        blk_count
`endif
);
   localparam int unsigned IW = $clog2(LATENCY + 1);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   pend_key_q, enc_key_q;
   logic [BLOCK_W-1:0] enc_block_q;
   logic               enc_vld_q;
   logic [LATENCY-1:0] tag_q;
   logic [IW-1:0]      inflight_q, inflight_d;
   logic [CW-1:0]      fifo_count;
   logic               fifo_empty;
   logic               key_ready, in_ready, credit_ok;
   logic               key_fire, in_fire, out_fire, tag_exit;

   // Credits cover both in-flight and buffered blocks, so a push never finds the FIFO full.
   assign credit_ok = (32'(inflight_q) + 32'(fifo_count)) < FIFO_DEPTH;
   assign key_fire  = bus.key_valid & key_ready;
   assign in_fire   = bus.in_valid & in_ready;
   assign out_fire  = ~fifo_empty & bus.out_ready;
   assign tag_exit  = tag_q[LATENCY-1];

   always_comb begin
      state_d   = state_q;
      key_ready = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         NOKEY: begin
            key_ready = 1'b1;
            if (bus.key_valid) state_d = LOAD;
         end
         RUN: begin
            key_ready = 1'b1;
            in_ready  = credit_ok;
            if (bus.key_valid) state_d = DRAIN;
         end
         DRAIN: begin
            if (inflight_q == '0) state_d = LOAD;
         end
         LOAD: begin
            state_d = RUN;
         end
         default: state_d = NOKEY;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (in_fire && !tag_exit)      inflight_d = inflight_q + IW'(1);
      else if (!in_fire && tag_exit) inflight_d = inflight_q - IW'(1);
   end

   // enc_vld_q rides alongside enc_block; the LATENCY-deep tag pipe then lines up with enc_encoded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= NOKEY;
         pend_key_q  <= '0;
         enc_key_q   <= '0;
         enc_block_q <= '0;
         enc_vld_q   <= 1'b0;
         tag_q       <= '0;
         inflight_q  <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         enc_vld_q  <= in_fire;
         tag_q      <= (tag_q << 1) | LATENCY'(enc_vld_q);
         if (key_fire)        pend_key_q  <= bus.key_in;
         if (state_q == LOAD) enc_key_q   <= pend_key_q;
         if (in_fire)         enc_block_q <= bus.in_block;
      end
   end

   kuz_out_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tag_exit),
      .din_i   (enc_encoded),
      .pop_i   (out_fire),
      .dout_o  (bus.out_block),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign bus.key_ready = key_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = ~fifo_empty;
   assign enc_block     = enc_block_q;
   assign enc_key       = enc_key_q;
   assign busy          = (inflight_q != '0) || (fifo_count != '0);

`ifdef KUZ_STREAM_CTRL_STATS_EN
   logic [31:0] blk_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           blk_count_q <= '0;
      else if (out_fire) blk_count_q <= blk_count_q + 32'd1;
   end

   assign blk_count = blk_count_q;
`endif

endmodule
